// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10 one per accepted handshake,
// computing each next key combinationally from the current one.
module aes_key_expand (
  input  logic         i_aes_key_expand_clk,
  input  logic         i_aes_key_expand_rst_n,
  input  logic         i_aes_key_expand_start,
  input  logic [127:0] i_aes_key_expand_key_in,
  input  logic         i_aes_key_expand_ready,
  output logic [127:0] o_aes_key_expand_round_key,
  output logic         o_aes_key_expand_valid,
  output logic [3:0]   o_aes_key_expand_round_num,
  output logic         o_aes_key_expand_busy,
  output logic         o_aes_key_expand_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // FIPS-197 S-box, byte 0x00 at the left (index 0) end.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t         state, state_nxt;
  logic [127:0]   key_p1, key_nxt;
  logic [3:0]     num_p1, num_nxt;
  logic           vld_p1, vld_nxt;
  logic           busy_p1, busy_nxt;
  logic           done_p1, done_nxt;
  logic           hs;
  logic [31:0]    w0, w1, w2, w3, temp;
  logic [31:0]    n0, n1, n2, n3;

  assign hs = vld_p1 & i_aes_key_expand_ready;

  assign w0   = key_p1[127:96];
  assign w1   = key_p1[95:64];
  assign w2   = key_p1[63:32];
  assign w3   = key_p1[31:0];
  assign temp = sub_word(rot_word(w3)) ^ {rcon(num_p1 + 4'd1), 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_ff @(posedge i_aes_key_expand_clk or negedge i_aes_key_expand_rst_n) begin
    if (!i_aes_key_expand_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_p1;
    num_nxt   = num_p1;
    vld_nxt   = vld_p1;
    busy_nxt  = busy_p1;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_aes_key_expand_start) begin
          key_nxt   = i_aes_key_expand_key_in;
          num_nxt   = 4'd0;
          vld_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        if (hs) begin
          if (num_p1 == LAST_ROUND) begin
            vld_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            key_nxt = {n0, n1, n2, n3};
            num_nxt = num_p1 + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge i_aes_key_expand_clk or negedge i_aes_key_expand_rst_n) begin
    if (!i_aes_key_expand_rst_n) begin
      key_p1  <= 128'h0;
      num_p1  <= 4'd0;
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      key_p1  <= key_nxt;
      num_p1  <= num_nxt;
      vld_p1  <= vld_nxt;
      busy_p1 <= busy_nxt;
      done_p1 <= done_nxt;
    end
  end

  assign o_aes_key_expand_round_key = key_p1;
  assign o_aes_key_expand_round_num = num_p1;
  assign o_aes_key_expand_valid     = vld_p1;
  assign o_aes_key_expand_busy      = busy_p1;
  assign o_aes_key_expand_done      = done_p1;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 round-key vectors.
module tb_aes_key_expand;

  typedef struct {
    logic         ready;
    logic [3:0]   num;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic [127:0] round_key;
  logic         valid;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  vec_t fips[11];

  always #5 clk = ~clk;

  aes_key_expand dut (
    .i_aes_key_expand_clk       (clk),
    .i_aes_key_expand_rst_n     (rst_n),
    .i_aes_key_expand_start     (start),
    .i_aes_key_expand_key_in    (key_in),
    .i_aes_key_expand_ready     (ready),
    .o_aes_key_expand_round_key (round_key),
    .o_aes_key_expand_valid     (valid),
    .o_aes_key_expand_round_num (round_num),
    .o_aes_key_expand_busy      (busy),
    .o_aes_key_expand_done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Steps with ready=1 until done is seen; returns whether it was seen in budget.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done) seen = 1'b1;
      else step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int idx;
    logic rdy;

    fips[0]  = '{1'b1, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fips[1]  = '{1'b1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[2]  = '{1'b1, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[3]  = '{1'b1, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[4]  = '{1'b1, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[5]  = '{1'b1, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{1'b1, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[7]  = '{1'b1, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[8]  = '{1'b1, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[9]  = '{1'b1, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[10] = '{1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = 128'h0;
    ready  = 1'b1;
    step();
    step();
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_num", round_num, 4'd0);
    chk("rst_key", round_key, 128'h0);
    rst_n  = 1'b1;
    key_in = KEY_A;
    step();
    step();
    chk("idle_valid", valid, 1'b0);
    chk("idle_key", round_key, 128'h0);

    // FIPS-197 expansion with ready held high
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fips_busy", busy, 1'b1);
    for (int i = 0; i < 11; i++) begin
      ready = fips[i].ready;
      chk($sformatf("fips_vld%0d", i), valid, 1'b1);
      chk($sformatf("fips_num%0d", i), round_num, fips[i].num);
      chk($sformatf("fips_key%0d", i), round_key, fips[i].key);
      step();
    end
    chk("fips_done", done, 1'b1);
    chk("fips_end_valid", valid, 1'b0);
    chk("fips_end_busy", busy, 1'b0);
    step();
    chk("fips_done_pulse", done, 1'b0);
    chk("fips_key_hold", round_key, fips[10].key);

    // Random backpressure
    key_in = KEY_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    idx   = 0;
    seen  = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        chk($sformatf("bp_vld_c%0d", c), valid, 1'b1);
        chk($sformatf("bp_num_c%0d", c), round_num, fips[idx > 10 ? 10 : idx].num);
        chk($sformatf("bp_key_c%0d", c), round_key, fips[idx > 10 ? 10 : idx].key);
        rdy   = 1'($urandom_range(0, 1));
        ready = rdy;
        step();
        if (rdy) idx++;
      end
    end
    chk("bp_done_seen", seen, 1'b1);
    chk("bp_count", idx, 11);
    ready = 1'b1;
    step();

    // start pulsed mid-expansion is ignored
    key_in = KEY_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("ign_num%0d", i), round_num, fips[i].num);
      chk($sformatf("ign_key%0d", i), round_key, fips[i].key);
      if (i == 4) begin
        start  = 1'b1;
        key_in = KEY_B;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("ign_done", done, 1'b1);
    step();

    // Asynchronous reset at round 6
    key_in = KEY_A;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_num6", round_num, 4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_key", round_key, 128'h0);
    chk("mid_rst_num", round_num, 4'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", valid, 1'b0);
    chk("post_rst_key", round_key, 128'h0);
    key_in = KEY_B;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("b_key0", round_key, KEY_B);
    step();
    chk("b_key1", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    for (int i = 0; i < 9; i++) step();
    chk("b_num10", round_num, 4'd10);
    chk("b_key10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    step();
    chk("b_done", done, 1'b1);
    step();

    // start held high: second expansion follows done immediately
    key_in = KEY_A;
    start  = 1'b1;
    step();
    wait_done(20, seen);
    chk("b2b_done_seen", seen, 1'b1);
    chk("b2b_done_valid", valid, 1'b0);
    step();
    chk("b2b_valid", valid, 1'b1);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_num", round_num, 4'd0);
    chk("b2b_key", round_key, KEY_A);
    chk("b2b_done_clear", done, 1'b0);
    start = 1'b0;
    wait_done(20, seen);
    chk("b2b_second_done", seen, 1'b1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
